alarm_clock_core: RTL and testbench
===================================

Name: alarm_clock_core

Overview:
Parametrised successor to the single-alarm board clock. It provides a 24-hour time-of-day counter with a configurable prescaler and NUM_ALARMS independently settable alarms. A button-driven edit FSM sets the time and the alarms. Outputs are BCD hour/minute/second digits for the 7-segment driver, plus per-alarm ringing flags for the LEDs or buzzer. It sits between the debounced button/switch inputs and the display multiplexer.

Parameters:
TICK_DIV, 100_000_000, clk cycles per second; must be >= 2.
NUM_ALARMS, 2, number of alarm channels, 1..8.
RING_SEC, 60, seconds an alarm rings before it auto-clears, 1..63.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous level clear: time goes to 00:00:00 and the prescaler goes to 0; alarms are kept
btn_c  in  1  mode advance (level, debounced; rising edge detected internally)
btn_u  in  1  increment selected field (edge)
btn_d  in  1  decrement selected field (edge)
btn_l  in  1  select hour field (edge)
btn_r  in  1  select minute field (edge)
alarm_en  in  NUM_ALARMS  per-alarm enable switches
alarm_ack  in  1  level; clears all ringing flags
hour_bcd  out  8  tens[7:4], ones[3:0]
min_bcd  out  8  BCD minutes
sec_bcd  out  8  BCD seconds
mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM
alarm_idx  out  max(1,$clog2(NUM_ALARMS))  alarm being edited
field_hour  out  1  1 = hour field selected
ringing  out  NUM_ALARMS  per-alarm ring flag
sec_pulse  out  1  one-cycle pulse when seconds advance

Behaviour:
Reset (rst_n low, async):
- time 00:00:00, all alarms 00:00
- mode RUN, alarm_idx 0, field_hour 1
- ringing 0, sec_pulse 0, prescaler 0
- edge-detect history registers 0

Edge detection:
- One register per button; the event is btn & ~prev.
- A button held through reset release gives no event.

Prescaler:
- Counts 0..TICK_DIV-1. tick = (count == TICK_DIV-1).
- sec_pulse is registered and asserts the cycle after tick.

Time:
- Seconds 0..59, then minute carry; minutes 0..59, then hour carry; hours 0..23, then wrap to 0.
- 23:59:59 plus one tick gives 00:00:00.

FSM (btn_c edge):
- RUN -> SET_TIME
- SET_TIME -> SET_ALARM with idx 0
- SET_ALARM idx k -> SET_ALARM idx k+1 while k < NUM_ALARMS-1; otherwise -> RUN
- field_hour is set to 1 on every btn_c transition.

SET_TIME:
- On entry, seconds are set to 0 and the prescaler is held at 0; time does not advance.
- btn_u/btn_d edit the selected field with wrap: min 59->0 and 0->59; hour 23->0 and 0->23.

SET_ALARM:
- Time keeps running.
- Edits apply to alarm[idx] with the same wrap rules.
- The display shows alarm hh:mm with sec_bcd = 8'h00.
- In RUN and SET_TIME the display shows the current time.

Button conflicts:
- btn_u and btn_d edges in the same cycle: no change.
- btn_l and btn_r in the same cycle: field unchanged.
- btn_c edge in the same cycle as btn_u/btn_d: the mode change wins and the edit is dropped.

clr:
- Has priority over tick and edits.
- Forces mode RUN only if the current mode is SET_TIME; otherwise mode is unchanged.

Alarm trigger:
- Alarm k triggers on the tick that makes the time equal alarm[k] hh:mm:00, if alarm_en[k]=1 and mode != SET_TIME.
- Trigger sets ringing[k] and loads ring_cnt[k] = RING_SEC.
- Several alarms may trigger in the same tick.

Alarm clear:
- ring_cnt[k] decrements on each tick while ringing[k]=1; ringing[k] clears when the count reaches 0 (RING_SEC seconds).
- ringing[k] also clears on alarm_ack or when alarm_en[k] is low.
- Clear has priority over a trigger in the same cycle.
- Setting time by hand onto an alarm value does not trigger it; only the tick-driven roll does.

Output timing:
- All outputs are registered or are pure BCD decode of registers.
- Display latency: one cycle after a state change.

Decomposition:
- Package alarm_clock_pkg holds:
  - mode enum (RUN, SET_TIME, SET_ALARM)
  - constants MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23
  - 6-bit time-field typedef
  - struct {hour, min} for alarm storage
- One sub-module, bcd2_split: 6-bit binary 0..59 to two BCD nibbles, combinational. It is instantiated three times on the display mux outputs.

Test Plan (TICK_DIV=4, NUM_ALARMS=2, RING_SEC=3):
1. Release reset, run 240 cycles -> time 00:01:00; sec_pulse seen 60 times, each one cycle wide, 4 cycles apart.
2. Enter SET_TIME, select hour, 25 btn_u edges -> hour 01. btn_d x2 -> 23. btn_r, then btn_d -> min 59. Exit to RUN and wait 1 second -> 23:59:01 wraps to 00:00:00 after 59 more seconds; hour_bcd=8'h00.
3. Set alarm0 00:02 and alarm1 00:02, alarm_en=2'b11, run from 00:01:59 -> both ringing bits set on the same tick, held 3 seconds, then cleared.
4. Alarm ringing and alarm_ack pulsed for 1 cycle -> ringing=0 the next cycle. A repeat trigger occurs only 24 h later (it does not retrigger within the minute).
5. btn_u and btn_d edges in the same cycle in SET_TIME -> value unchanged. btn_c plus btn_u in the same cycle -> mode advances and the value is unchanged.
6. Assert rst_n low mid-SET_ALARM with ringing=1 -> immediately mode=0, ringing=0, all BCD outputs 8'h00. A held btn_c at release gives no mode change.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared types, limits and wrap helper for the alarm clock
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    typedef logic [5:0] tfield_t;

    typedef struct packed {
        tfield_t hour;
        tfield_t min;
    } alarm_t;

    localparam tfield_t MAX_SEC  = 6'd59;
    localparam tfield_t MAX_MIN  = 6'd59;
    localparam tfield_t MAX_HOUR = 6'd23;

    // One up/down step of a time field, wrapping at both ends.
    function automatic tfield_t wrap_step(input tfield_t v, input tfield_t max_v, input logic up);
        if (up) begin
            return (v == max_v) ? '0 : v + 6'd1;
        end
        return (v == '0) ? max_v : v - 6'd1;
    endfunction

endpackage

// File: rtl/bcd2_split.sv
// rtl/bcd2_split.sv - binary 0..59 to two BCD digits
module bcd2_split (
    input  logic [5:0] bin_i,
    output logic [7:0] bcd_o
);

    logic [3:0] tens;
    logic [3:0] ones;

    always_comb begin
        tens = 4'd0;
        ones = bin_i[3:0];
        if (bin_i >= 6'd50) begin
            tens = 4'd5;
            ones = 4'(bin_i - 6'd50);
        end else if (bin_i >= 6'd40) begin
            tens = 4'd4;
            ones = 4'(bin_i - 6'd40);
        end else if (bin_i >= 6'd30) begin
            tens = 4'd3;
            ones = 4'(bin_i - 6'd30);
        end else if (bin_i >= 6'd20) begin
            tens = 4'd2;
            ones = 4'(bin_i - 6'd20);
        end else if (bin_i >= 6'd10) begin
            tens = 4'd1;
            ones = 4'(bin_i - 6'd10);
        end
    end

    assign bcd_o = {tens, ones};

endmodule

// File: rtl/alarm_clock_core.sv
// rtl/alarm_clock_core.sv - 24h clock with prescaler, button edit FSM and multiple alarms
module alarm_clock_core
    import alarm_clock_pkg::*;
#(
    parameter  int TICK_DIV   = 100_000_000,
    parameter  int NUM_ALARMS = 2,
    parameter  int RING_SEC   = 60,
    localparam int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int PRE_W      = $clog2(TICK_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  btn_c,
    input  logic                  btn_u,
    input  logic                  btn_d,
    input  logic                  btn_l,
    input  logic                  btn_r,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  alarm_ack,
    output logic [7:0]            hour_bcd,
    output logic [7:0]            min_bcd,
    output logic [7:0]            sec_bcd,
    output logic [1:0]            mode,
    output logic [IDX_W-1:0]      alarm_idx,
    output logic                  field_hour,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  sec_pulse
);

    logic [4:0]            btn_prev_q, btn_prev_d, btn_now, btn_ev;
    logic                  armed_q, armed_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    tfield_t               sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    mode_e                 mode_q, mode_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  fh_q, fh_d;
    alarm_t                alarm_q [NUM_ALARMS];
    alarm_t                alarm_d [NUM_ALARMS];
    logic [5:0]            ring_cnt_q [NUM_ALARMS];
    logic [5:0]            ring_cnt_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] ringing_q, ringing_d, trig;
    logic                  sec_pulse_q, sec_pulse_d;

    logic    ev_c, ev_u, ev_d, ev_l, ev_r;
    logic    tick, enter_set, edit, time_adv;
    tfield_t roll_sec, roll_min, roll_hour;
    tfield_t disp_h, disp_m, disp_s;

    // The first cycle after reset only primes the history, so a held button is not an event.
    assign btn_now = {btn_c, btn_u, btn_d, btn_l, btn_r};
    assign btn_ev  = armed_q ? (btn_now & ~btn_prev_q) : 5'd0;
    assign {ev_c, ev_u, ev_d, ev_l, ev_r} = btn_ev;

    assign tick      = (presc_q == PRE_W'(TICK_DIV - 1));
    assign enter_set = ev_c && (mode_q == MODE_RUN);
    assign edit      = !ev_c && (ev_u ^ ev_d);
    assign time_adv  = tick && !clr && !enter_set && (mode_q != MODE_SET_TIME);

    assign roll_sec  = (sec_q == MAX_SEC) ? '0 : sec_q + 6'd1;
    assign roll_min  = (sec_q == MAX_SEC) ? wrap_step(min_q, MAX_MIN, 1'b1) : min_q;
    assign roll_hour = (sec_q == MAX_SEC && min_q == MAX_MIN) ? wrap_step(hour_q, MAX_HOUR, 1'b1) : hour_q;

    always_comb begin
        btn_prev_d  = btn_now;
        armed_d     = 1'b1;
        presc_d     = presc_q + PRE_W'(1);
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        fh_d        = fh_q;
        alarm_d     = alarm_q;
        ring_cnt_d  = ring_cnt_q;
        ringing_d   = ringing_q;
        trig        = '0;
        sec_pulse_d = time_adv;

        if (clr || enter_set || tick || mode_q == MODE_SET_TIME) begin
            presc_d = '0;
        end

        if (clr) begin
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (enter_set) begin
            sec_d = '0;
        end else if (time_adv) begin
            sec_d  = roll_sec;
            min_d  = roll_min;
            hour_d = roll_hour;
        end else if (mode_q == MODE_SET_TIME && edit) begin
            if (fh_q) hour_d = wrap_step(hour_q, MAX_HOUR, ev_u);
            else      min_d  = wrap_step(min_q, MAX_MIN, ev_u);
        end

        if (ev_c) begin
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_TIME;
                MODE_SET_TIME: begin
                    mode_d = MODE_SET_ALARM;
                    idx_d  = '0;
                end
                MODE_SET_ALARM: begin
                    if (idx_q < IDX_W'(NUM_ALARMS - 1)) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        mode_d = MODE_RUN;
                        idx_d  = '0;
                    end
                end
                default: mode_d = MODE_RUN;
            endcase
            fh_d = 1'b1;
        end else if (ev_l && !ev_r) begin
            fh_d = 1'b1;
        end else if (ev_r && !ev_l) begin
            fh_d = 1'b0;
        end
        if (clr && mode_q == MODE_SET_TIME) begin
            mode_d = MODE_RUN;
        end

        for (int k = 0; k < NUM_ALARMS; k++) begin
            if (mode_q == MODE_SET_ALARM && edit && !clr && idx_q == IDX_W'(k)) begin
                if (fh_q) alarm_d[k].hour = wrap_step(alarm_q[k].hour, MAX_HOUR, ev_u);
                else      alarm_d[k].min  = wrap_step(alarm_q[k].min, MAX_MIN, ev_u);
            end
            // Only the tick-driven roll onto hh:mm:00 fires an alarm, never a hand edit.
            trig[k] = time_adv && alarm_en[k] && roll_sec == '0 &&
                      roll_min == alarm_q[k].min && roll_hour == alarm_q[k].hour;
            if (alarm_ack || !alarm_en[k]) begin
                ringing_d[k]  = 1'b0;
                ring_cnt_d[k] = '0;
            end else if (trig[k]) begin
                ringing_d[k]  = 1'b1;
                ring_cnt_d[k] = 6'(RING_SEC);
            end else if (ringing_q[k] && time_adv) begin
                ring_cnt_d[k] = ring_cnt_q[k] - 6'd1;
                if (ring_cnt_q[k] == 6'd1) ringing_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q  <= '0;
            armed_q     <= 1'b0;
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            mode_q      <= MODE_RUN;
            idx_q       <= '0;
            fh_q        <= 1'b1;
            ringing_q   <= '0;
            sec_pulse_q <= 1'b0;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                alarm_q[k]    <= '0;
                ring_cnt_q[k] <= '0;
            end
        end else begin
            btn_prev_q  <= btn_prev_d;
            armed_q     <= armed_d;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            fh_q        <= fh_d;
            ringing_q   <= ringing_d;
            sec_pulse_q <= sec_pulse_d;
            alarm_q     <= alarm_d;
            ring_cnt_q  <= ring_cnt_d;
        end
    end

    always_comb begin
        disp_h = hour_q;
        disp_m = min_q;
        disp_s = sec_q;
        if (mode_q == MODE_SET_ALARM) begin
            disp_s = '0;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    disp_h = alarm_q[k].hour;
                    disp_m = alarm_q[k].min;
                end
            end
        end
    end

    bcd2_split u_bcd_hour (.bin_i(disp_h), .bcd_o(hour_bcd));
    bcd2_split u_bcd_min  (.bin_i(disp_m), .bcd_o(min_bcd));
    bcd2_split u_bcd_sec  (.bin_i(disp_s), .bcd_o(sec_bcd));

    assign mode       = mode_q;
    assign alarm_idx  = idx_q;
    assign field_hour = fh_q;
    assign ringing    = ringing_q;
    assign sec_pulse  = sec_pulse_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// tb/tb_alarm_clock_core.sv - scoreboard bench for alarm_clock_core
module tb_alarm_clock_core;

    localparam int TICK_DIV   = 4;
    localparam int NUM_ALARMS = 2;
    localparam int RING_SEC   = 3;

    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n, clr, btn_c, btn_u, btn_d, btn_l, btn_r, alarm_ack;
    logic [1:0] alarm_en;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic [0:0] alarm_idx;
    logic       field_hour;
    logic [1:0] ringing;
    logic       sec_pulse;

    always #5 clk = ~clk;

    alarm_clock_core #(
        .TICK_DIV  (TICK_DIV),
        .NUM_ALARMS(NUM_ALARMS),
        .RING_SEC  (RING_SEC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .btn_c     (btn_c),
        .btn_u     (btn_u),
        .btn_d     (btn_d),
        .btn_l     (btn_l),
        .btn_r     (btn_r),
        .alarm_en  (alarm_en),
        .alarm_ack (alarm_ack),
        .hour_bcd  (hour_bcd),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .mode      (mode),
        .alarm_idx (alarm_idx),
        .field_hour(field_hour),
        .ringing   (ringing),
        .sec_pulse (sec_pulse)
    );

    typedef struct packed {
        logic [23:0] t;
        logic [1:0]  mode;
        logic        idx;
        logic        fh;
        logic [1:0]  ring;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    logic [1:0] e_mode = 2'd0;
    logic       e_idx  = 1'b0;
    logic       e_fh   = 1'b1;
    logic [1:0] e_ring = 2'b00;

    int   cyc = 0;
    int   pulse_cnt = 0, pulse_bad = 0, last_pulse = 0;
    logic pulse_win = 1'b0, win_prev = 1'b0, prev_pulse = 1'b0;

    task automatic expect_state(input string nm, input logic [23:0] t);
        exp_t e;
        e.t    = t;
        e.mode = e_mode;
        e.idx  = e_idx;
        e.fh   = e_fh;
        e.ring = e_ring;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string nm;
        logic  ok;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            ok = ({hour_bcd, min_bcd, sec_bcd} === e.t) && (mode === e.mode) &&
                 (field_hour === e.fh) && (ringing === e.ring) &&
                 ((e.mode != 2'd2) || (alarm_idx === e.idx));
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got time=%h mode=%0d idx=%0d fh=%0d ring=%b, expected time=%h mode=%0d idx=%0d fh=%0d ring=%b",
                         nm, {hour_bcd, min_bcd, sec_bcd}, mode, alarm_idx, field_hour, ringing,
                         e.t, e.mode, e.idx, e.fh, e.ring);
            end
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : pulse_mon
        if (pulse_win && !win_prev) last_pulse = cyc;
        if (pulse_win && sec_pulse) begin
            if (prev_pulse) pulse_bad++;
            if (cyc - last_pulse != TICK_DIV) pulse_bad++;
            last_pulse = cyc;
            pulse_cnt++;
        end
        prev_pulse = sec_pulse;
        win_prev   = pulse_win;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = b;
        @(posedge clk);
        #1;
        {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; alarm_ack = 1'b0; alarm_en = 2'b00;
        {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;

        // reset state and free-running seconds
        wait_cycles(2);
        expect_state("reset_state", 24'h000000);
        check_val("sec_pulse_reset", int'(sec_pulse), 0);
        wait_cycles(1);
        rst_n = 1'b1;
        pulse_win = 1'b1;
        wait_cycles(240);
        expect_state("one_minute", 24'h000100);
        @(negedge clk);
        #1;
        pulse_win = 1'b0;
        check_val("sec_pulse_count", pulse_cnt, 60);
        check_val("sec_pulse_shape", pulse_bad, 0);
        wait_cycles(1);

        // clear, then set time with wraps and conflicts
        clr = 1'b1;
        wait_cycles(1);
        clr = 1'b0;
        expect_state("clr", 24'h000000);
        press(B_C); e_mode = 2'd1;
        expect_state("enter_set_time", 24'h000000);
        press(B_L);
        for (int i = 0; i < 25; i++) press(B_U);
        expect_state("hour_wrap_up", 24'h010000);
        press(B_D);
        press(B_D);
        expect_state("hour_wrap_down", 24'h230000);
        press(B_R); e_fh = 1'b0;
        press(B_L | B_R);
        press(B_D);
        expect_state("min_wrap_down", 24'h235900);
        press(B_U | B_D);
        expect_state("up_down_conflict", 24'h235900);
        press(B_C | B_U); e_mode = 2'd2; e_idx = 1'b0; e_fh = 1'b1;
        expect_state("mode_beats_edit", 24'h000000);
        press(B_C); e_idx = 1'b1;
        expect_state("alarm1_view", 24'h000000);
        press(B_C); e_mode = 2'd0;
        expect_state("run_after_set", 24'h235901);
        wait_cycles(234);
        expect_state("before_midnight", 24'h235959);
        wait_cycles(1);
        expect_state("midnight_wrap", 24'h000000);

        // two alarms on the same minute
        press(B_C); e_mode = 2'd1;
        press(B_R); e_fh = 1'b0;
        press(B_U);
        expect_state("time_set_0001", 24'h000100);
        press(B_C); e_mode = 2'd2; e_idx = 1'b0; e_fh = 1'b1;
        press(B_R); e_fh = 1'b0;
        press(B_U);
        press(B_U);
        expect_state("alarm0_0002", 24'h000200);
        press(B_C); e_idx = 1'b1; e_fh = 1'b1;
        press(B_R); e_fh = 1'b0;
        press(B_U);
        press(B_U);
        expect_state("alarm1_0002", 24'h000200);
        press(B_C); e_mode = 2'd0; e_fh = 1'b1;
        alarm_en = 2'b11;
        expect_state("run_before_alarm", 24'h000104);
        wait_cycles(222);
        expect_state("alarm_minus_1s", 24'h000159);
        wait_cycles(1); e_ring = 2'b11;
        expect_state("both_alarms_ring", 24'h000200);
        wait_cycles(11);
        expect_state("still_ringing", 24'h000202);
        wait_cycles(1); e_ring = 2'b00;
        expect_state("ring_timeout", 24'h000203);

        // hand-set time onto an alarm, ack, no retrigger
        press(B_C); e_mode = 2'd1;
        expect_state("set_time_onto_alarm", 24'h000200);
        press(B_C); e_mode = 2'd2; e_idx = 1'b0;
        press(B_R); e_fh = 1'b0;
        press(B_U);
        expect_state("alarm0_0003", 24'h000300);
        press(B_C); e_idx = 1'b1; e_fh = 1'b1;
        press(B_R); e_fh = 1'b0;
        press(B_U);
        press(B_U);
        expect_state("alarm1_0004", 24'h000400);
        press(B_C); e_mode = 2'd0; e_fh = 1'b1;
        expect_state("run_again", 24'h000203);
        wait_cycles(225); e_ring = 2'b01;
        expect_state("alarm0_ring", 24'h000300);
        alarm_ack = 1'b1;
        wait_cycles(1);
        alarm_ack = 1'b0; e_ring = 2'b00;
        expect_state("ack_clears", 24'h000300);
        wait_cycles(20);
        expect_state("no_retrigger", 24'h000305);
        wait_cycles(219); e_ring = 2'b10;
        expect_state("alarm1_ring", 24'h000400);

        // reset while ringing in SET_ALARM, button held through release
        press(B_C); e_mode = 2'd1;
        press(B_C); e_mode = 2'd2; e_idx = 1'b0;
        expect_state("ring_in_set_alarm", 24'h000300);
        wait_cycles(1);
        btn_c = 1'b1;
        rst_n = 1'b0;
        e_mode = 2'd0; e_fh = 1'b1; e_ring = 2'b00;
        expect_state("reset_mid_alarm", 24'h000000);
        #1;
        check_val("sec_pulse_in_reset", int'(sec_pulse), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(4);
        expect_state("held_btn_c_no_event", 24'h000001);
        btn_c = 1'b0;
        wait_cycles(2);
        @(negedge clk);
        #1;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
